// File: rtl/dsp_vec_unit.sv
// dsp_vec_unit: a vector arithmetic unit with LANES lanes of DATA_W bits each.
// It processes one lane per clock cycle.
//
// A rising edge on start, seen in idle, launches one operation. The operands and the
// opcode are latched at launch. The unit then works through lanes 0..LANES-1 on
// successive edges. When it finishes, it commits the work vector to result and pulses
// done for one cycle.
//
// Ports:
//   clk        DSP clock
//   rst        synchronous, active-high reset
//   start      level launch request; only its rising edge matters
//   operation  2'b00 add, 2'b01 sub, 2'b10 mul (low DATA_W bits, signed), 2'b11 dot product
//   a, b       operand vectors; lane i occupies [i*DATA_W +: DATA_W]
//   result     result vector, same packing; holds its value between completions
//   done       one-cycle completion pulse (memory write enable)
//   busy       high while an operation is in flight (EXEC and DONE)
module dsp_vec_unit #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                operation,
  input  logic [LANES*DATA_W-1:0]   a,
  input  logic [LANES*DATA_W-1:0]   b,
  output logic [LANES*DATA_W-1:0]   result,
  output logic                      done,
  output logic                      busy
);

  localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LANES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpMul = 2'b10,
    OpDot = 2'b11
  } op_e;

  state_e                    state_q, state_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic                      start_prev_q, start_prev_d;
  logic [LANES*DATA_W-1:0]   a_q, a_d;
  logic [LANES*DATA_W-1:0]   b_q, b_d;
  logic [1:0]                op_q, op_d;
  logic [LANES*DATA_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]         acc_q, acc_d;
  logic [LANES*DATA_W-1:0]   result_q, result_d;

  logic                      launch;
  logic [DATA_W-1:0]         lane_a, lane_b, lane_prod;

  assign launch = start & ~start_prev_q;

  always_comb begin
    lane_a    = a_q[idx_q*DATA_W +: DATA_W];
    lane_b    = b_q[idx_q*DATA_W +: DATA_W];
    // The low DATA_W bits of a two's-complement product do not depend on signedness.
    lane_prod = lane_a * lane_b;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    start_prev_d = start;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    work_d       = work_q;
    acc_d        = acc_q;
    result_d     = result_q;

    unique case (state_q)
      StIdle: begin
        if (launch) begin
          a_d     = a;
          b_d     = b;
          op_d    = operation;
          work_d  = '0;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StExec;
        end
      end
      StExec: begin
        unique case (op_e'(op_q))
          OpAdd: work_d[idx_q*DATA_W +: DATA_W] = lane_a + lane_b;
          OpSub: work_d[idx_q*DATA_W +: DATA_W] = lane_a - lane_b;
          OpMul: work_d[idx_q*DATA_W +: DATA_W] = lane_prod;
          OpDot: acc_d = acc_q + lane_prod;
          default: ;
        endcase
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
          // Commit includes the lane processed on this same edge.
          if (op_e'(op_q) == OpDot) begin
            result_d              = '0;
            result_d[DATA_W-1:0]  = acc_d;
          end else begin
            result_d = work_d;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      start_prev_q <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      work_q       <= '0;
      acc_q        <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      start_prev_q <= start_prev_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      work_q       <= work_d;
      acc_q        <= acc_d;
      result_q     <= result_d;
    end
  end

  assign result = result_q;
  assign done   = (state_q == StDone);
  assign busy   = (state_q != StIdle);

endmodule
